// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings and the parity check helper.
// Used by both the RX frame checker and the TX side.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // data_xor is the XOR-reduction of the data bits; par_bit is the received parity bit.
  function automatic logic parity_error(input logic [1:0] mode,
                                        input logic       data_xor,
                                        input logic       par_bit);
    logic p;
    p = data_xor ^ par_bit;
    case (mode)
      PAR_EVEN: parity_error = p;
      PAR_ODD:  parity_error = ~p;
      PAR_MARK: parity_error = ~par_bit;
      default:  parity_error = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_err_counter.sv
// Saturating event counter with synchronous clear; clear takes priority over increment.
module uart_err_counter #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ERR_CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {ERR_CNT_W{1'b1}})) begin
      cnt <= cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// RX frame checker: two-entry buffer (capture A, output B) with parity/stop checks,
// valid/ready delivery, overrun detection and saturating error counters.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ERR_CNT_W   = 8,
  parameter bit DROP_ON_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 frame_load,
  input  logic [DATA_W-1:0]    data_sipo,
  input  logic                 parity_in,
  input  logic [1:0]           stop_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_cnt,
  output logic [ERR_CNT_W-1:0] parity_cnt,
  output logic [ERR_CNT_W-1:0] frame_cnt,
  output logic [ERR_CNT_W-1:0] overrun_cnt
);

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_par;
  logic [1:0]        a_stop;
  logic [1:0]        a_mode;
  logic              a_two;

  logic              move;
  logic              a_load;
  logic              drop;
  logic              chk_perr;
  logic              chk_ferr;
  logic [DATA_W-1:0] chk_data;

  assign move   = a_valid & (~data_valid | data_ready);
  // A load in the same cycle A drains into B is accepted, not an overrun.
  assign a_load = frame_load & (~a_valid | move);
  assign drop   = frame_load & a_valid & ~move;

  // Checks use the mode latched with the frame, never the live mode inputs.
  assign chk_perr = parity_error(a_mode, ^a_data, a_par);
  assign chk_ferr = ~a_stop[0] | (a_two & ~a_stop[1]);
  assign chk_data = (DROP_ON_ERR && (chk_perr || chk_ferr)) ? '0 : a_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_par   <= 1'b0;
      a_stop  <= 2'b00;
      a_mode  <= PAR_NONE;
      a_two   <= 1'b0;
    end else if (a_load) begin
      a_valid <= 1'b1;
      a_data  <= data_sipo;
      a_par   <= parity_in;
      a_stop  <= stop_in;
      a_mode  <= parity_mode;
      a_two   <= two_stop;
    end else if (move) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_valid <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (move) begin
      data_valid <= 1'b1;
      data_out   <= chk_data;
      parity_err <= chk_perr;
      frame_err  <= chk_ferr;
    end else if (data_ready) begin
      data_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else begin
      overrun <= drop;
    end
  end

  uart_err_counter #(.ERR_CNT_W(ERR_CNT_W)) u_parity_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (move & chk_perr),
    .clr   (clr_cnt),
    .cnt   (parity_cnt)
  );

  uart_err_counter #(.ERR_CNT_W(ERR_CNT_W)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (move & chk_ferr),
    .clr   (clr_cnt),
    .cnt   (frame_cnt)
  );

  uart_err_counter #(.ERR_CNT_W(ERR_CNT_W)) u_overrun_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .clr   (clr_cnt),
    .cnt   (overrun_cnt)
  );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: two instances (8-bit counters / 2-bit counters with
// error data dropping) share stimulus and are checked against a queue-based frame model.
module tb_uart_rx_frame_check;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       frame_load;
  logic [7:0] data_sipo;
  logic       parity_in;
  logic [1:0] stop_in;
  logic       data_ready;
  logic       clr_cnt;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1, pe0, pe1, fe0, fe1, ov0, ov1;
  logic [7:0] pc0, fc0, oc0;
  logic [1:0] pc1, fc1, oc1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_rx_frame_check #(.DATA_W(8), .ERR_CNT_W(8), .DROP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .reset(reset), .parity_mode(parity_mode), .two_stop(two_stop),
    .frame_load(frame_load), .data_sipo(data_sipo), .parity_in(parity_in), .stop_in(stop_in),
    .data_out(dout0), .data_valid(dv0), .data_ready(data_ready), .parity_err(pe0),
    .frame_err(fe0), .overrun(ov0), .clr_cnt(clr_cnt), .parity_cnt(pc0),
    .frame_cnt(fc0), .overrun_cnt(oc0)
  );

  uart_rx_frame_check #(.DATA_W(8), .ERR_CNT_W(2), .DROP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .parity_mode(parity_mode), .two_stop(two_stop),
    .frame_load(frame_load), .data_sipo(data_sipo), .parity_in(parity_in), .stop_in(stop_in),
    .data_out(dout1), .data_valid(dv1), .data_ready(data_ready), .parity_err(pe1),
    .frame_err(fe1), .overrun(ov1), .clr_cnt(clr_cnt), .parity_cnt(pc1),
    .frame_cnt(fc1), .overrun_cnt(oc1)
  );

  // Reference model: frames in flight, oldest first; vis marks the one presented on the output.
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       vis;
  } frm_t;

  frm_t mq[$];
  int   raw_pc, raw_fc, raw_oc;
  logic m_ov;

  function automatic logic ref_perr(input logic [1:0] mode, input logic [7:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    case (mode)
      PAR_EVEN: return (ones % 2) != 0;
      PAR_ODD:  return (ones % 2) == 0;
      PAR_MARK: return p == 1'b0;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    mq.delete();
    raw_pc = 0;
    raw_fc = 0;
    raw_oc = 0;
    m_ov   = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs present at that edge.
  task automatic tick();
    frm_t f;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (mq.size() > 0 && mq[0].vis && data_ready) void'(mq.pop_front());
      if (mq.size() > 0 && !mq[0].vis) begin
        f = mq[0];
        f.vis = 1'b1;
        mq[0] = f;
        raw_pc += int'(f.pe);
        raw_fc += int'(f.fe);
      end
      m_ov = 1'b0;
      if (frame_load) begin
        if (mq.size() < 2) begin
          f.d   = data_sipo;
          f.pe  = ref_perr(parity_mode, data_sipo, parity_in);
          f.fe  = !stop_in[0] || (two_stop && !stop_in[1]);
          f.vis = 1'b0;
          mq.push_back(f);
        end else begin
          m_ov = 1'b1;
          raw_oc++;
        end
      end
      if (clr_cnt) begin
        raw_pc = 0;
        raw_fc = 0;
        raw_oc = 0;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    frame_load = 1'b0;
    clr_cnt    = 1'b0;
  endtask

  task automatic drive_frame(input logic [1:0] mode, input logic two, input logic [7:0] d,
                             input logic p, input logic [1:0] s);
    parity_mode = mode;
    two_stop    = two;
    data_sipo   = d;
    parity_in   = p;
    stop_in     = s;
    frame_load  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    data_ready = 1'b0;
    drive_frame(PAR_NONE, 1'b0, 8'h00, 1'b0, 2'b11);
    frame_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({dv0, dout0, pe0, fe0, ov0, pc0, fc0, oc0} !== 36'd0) begin
      tests_failed++;
      $display("FAIL reset_out0: got %h want 0", {dv0, dout0, pe0, fe0, ov0, pc0, fc0, oc0});
    end
    tests_run++;
    if ({dv1, dout1, pe1, fe1, ov1, pc1, fc1, oc1} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_out1: got %h want 0", {dv1, dout1, pe1, fe1, ov1, pc1, fc1, oc1});
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    tick();
    tests_run++;
    if ({dv0, ov0, pc0, fc0, oc0} !== 26'd0) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want 0", {dv0, ov0, pc0, fc0, oc0});
    end
  endtask

  task automatic test_even_clean();
    data_ready = 1'b1;
    drive_frame(PAR_EVEN, 1'b0, 8'hA5, 1'b0, 2'b11);
    tick();
    set_idle();
    tests_run++;
    if (dv0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL even_latency_n1: data_valid got %b want 0", dv0);
    end
    tick();
    tests_run++;
    if ({dv0, dout0, pe0, fe0} !== {1'b1, 8'hA5, 2'b00}) begin
      tests_failed++;
      $display("FAIL even_clean: got dv=%b d=%h pe=%b fe=%b want dv=1 d=a5 pe=0 fe=0",
               dv0, dout0, pe0, fe0);
    end
    tick();
    tests_run++;
    if (dv0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL even_accepted: data_valid got %b want 0", dv0);
    end
  endtask

  task automatic test_parity_odd();
    data_ready = 1'b1;
    drive_frame(PAR_ODD, 1'b0, 8'hA5, 1'b0, 2'b11);
    tick();
    set_idle();
    tick();
    tests_run++;
    if ({dv0, dout0, pe0, fe0, pc0} !== {1'b1, 8'hA5, 1'b1, 1'b0, 8'd1}) begin
      tests_failed++;
      $display("FAIL odd_parity0: got dv=%b d=%h pe=%b fe=%b pc=%0d want 1 a5 1 0 1",
               dv0, dout0, pe0, fe0, pc0);
    end
    tests_run++;
    if ({dv1, dout1, pe1, pc1} !== {1'b1, 8'h00, 1'b1, 2'd1}) begin
      tests_failed++;
      $display("FAIL odd_parity_drop: got dv=%b d=%h pe=%b pc=%0d want 1 00 1 1",
               dv1, dout1, pe1, pc1);
    end
    tick();
  endtask

  task automatic test_stop_bits();
    data_ready = 1'b1;
    drive_frame(PAR_EVEN, 1'b1, 8'h3C, 1'b0, 2'b01);
    tick();
    drive_frame(PAR_EVEN, 1'b0, 8'h3C, 1'b0, 2'b01);
    tick();
    set_idle();
    tests_run++;
    if ({dv0, dout0, pe0, fe0, fc0, dout1} !== {1'b1, 8'h3C, 1'b0, 1'b1, 8'd1, 8'h00}) begin
      tests_failed++;
      $display("FAIL two_stop_err: got dv=%b d=%h pe=%b fe=%b fc=%0d d1=%h want 1 3c 0 1 1 00",
               dv0, dout0, pe0, fe0, fc0, dout1);
    end
    tick();
    tests_run++;
    if ({dv0, dout0, pe0, fe0, fc0, dout1} !== {1'b1, 8'h3C, 1'b0, 1'b0, 8'd1, 8'h3C}) begin
      tests_failed++;
      $display("FAIL one_stop_clean: got dv=%b d=%h pe=%b fe=%b fc=%0d d1=%h want 1 3c 0 0 1 3c",
               dv0, dout0, pe0, fe0, fc0, dout1);
    end
    tick();
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    drive_frame(PAR_NONE, 1'b0, 8'h11, 1'b0, 2'b11);
    tick();
    drive_frame(PAR_NONE, 1'b0, 8'h22, 1'b0, 2'b11);
    tick();
    set_idle();
    tick();
    drive_frame(PAR_NONE, 1'b0, 8'h33, 1'b0, 2'b11);
    tick();
    set_idle();
    tests_run++;
    if ({ov0, oc0, dv0, dout0, ov1, oc1} !== {1'b1, 8'd1, 1'b1, 8'h11, 1'b1, 2'd1}) begin
      tests_failed++;
      $display("FAIL overrun_pulse: got ov=%b oc=%0d dv=%b d=%h ov1=%b oc1=%0d want 1 1 1 11 1 1",
               ov0, oc0, dv0, dout0, ov1, oc1);
    end
    tick();
    tests_run++;
    if ({ov0, oc0, dv0, dout0} !== {1'b0, 8'd1, 1'b1, 8'h11}) begin
      tests_failed++;
      $display("FAIL overrun_hold: got ov=%b oc=%0d dv=%b d=%h want 0 1 1 11", ov0, oc0, dv0, dout0);
    end
    data_ready = 1'b1;
    tick();
    tests_run++;
    if ({dv0, dout0} !== {1'b1, 8'h22}) begin
      tests_failed++;
      $display("FAIL overrun_second: got dv=%b d=%h want 1 22", dv0, dout0);
    end
    tick();
    tests_run++;
    if (dv0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_dropped: data_valid got %b want 0 (frame 33 must be lost)", dv0);
    end
  endtask

  task automatic test_saturation();
    data_ready = 1'b1;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tests_run++;
    if ({pc0, fc0, oc0, pc1, fc1, oc1} !== 30'd0) begin
      tests_failed++;
      $display("FAIL clr_cnt: got %h want 0", {pc0, fc0, oc0, pc1, fc1, oc1});
    end
    for (int i = 0; i < 5; i++) begin
      drive_frame(PAR_ODD, 1'b0, 8'hA5, 1'b0, 2'b11);
      tick();
    end
    set_idle();
    repeat (2) tick();
    tests_run++;
    if ({pc0, pc1} !== {8'd5, 2'd3}) begin
      tests_failed++;
      $display("FAIL saturate: got pc0=%0d pc1=%0d want 5 3", pc0, pc1);
    end
    drive_frame(PAR_ODD, 1'b0, 8'hA5, 1'b0, 2'b11);
    tick();
    set_idle();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tests_run++;
    if ({dv0, pe0, pc0, pc1} !== {1'b1, 1'b1, 8'd0, 2'd0}) begin
      tests_failed++;
      $display("FAIL clr_wins: got dv=%b pe=%b pc0=%0d pc1=%0d want 1 1 0 0", dv0, pe0, pc0, pc1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    data_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive_frame(PAR_NONE, 1'b0, 8'(i * 17 + 3), 1'b0, 2'b11);
      else set_idle();
      tick();
      if (i >= 1 && i <= 8) begin
        d = 8'((i - 1) * 17 + 3);
        tests_run++;
        if ({dv0, dout0, ov0} !== {1'b1, d, 1'b0}) begin
          tests_failed++;
          $display("FAIL b2b_%0d: got dv=%b d=%h ov=%b want 1 %h 0", i, dv0, dout0, ov0, d);
        end
      end
    end
    tests_run++;
    if (dv0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: data_valid got %b want 0", dv0);
    end
  endtask

  task automatic test_reset_midflight();
    data_ready = 1'b0;
    drive_frame(PAR_ODD, 1'b0, 8'hA5, 1'b0, 2'b00);
    tick();
    tick();
    set_idle();
    tests_run++;
    if (dv0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_setup: data_valid got %b want 1", dv0);
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({dv0, dout0, pe0, fe0, ov0, pc0, fc0, oc0, dv1, pc1, fc1, oc1} !== 43'd0) begin
      tests_failed++;
      $display("FAIL midrst_clear: got %h want 0",
               {dv0, dout0, pe0, fe0, ov0, pc0, fc0, oc0, dv1, pc1, fc1, oc1});
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    data_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({dv0, pc0, fc0} !== 17'd0) begin
      tests_failed++;
      $display("FAIL midrst_no_ghost: got dv=%b pc=%0d fc=%0d want 0 0 0", dv0, pc0, fc0);
    end
    drive_frame(PAR_EVEN, 1'b0, 8'h5A, 1'b0, 2'b11);
    tick();
    set_idle();
    tick();
    tests_run++;
    if ({dv0, dout0, pe0, fe0, pc0} !== {1'b1, 8'h5A, 1'b0, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL midrst_first: got dv=%b d=%h pe=%b fe=%b pc=%0d want 1 5a 0 0 0",
               dv0, dout0, pe0, fe0, pc0);
    end
    tick();
  endtask

  task automatic test_random();
    logic        exp_dv;
    frm_t        h;
    logic [23:0] e_c0;
    logic [5:0]  e_c1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(9) < 6)
        drive_frame(2'($urandom_range(3)), 1'($urandom_range(1)), 8'($urandom),
                    1'($urandom_range(1)), ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b11);
      else
        frame_load = 1'b0;
      data_ready = ($urandom_range(9) < 7);
      clr_cnt    = ($urandom_range(99) == 0);
      tick();
      exp_dv = (mq.size() > 0) && mq[0].vis;
      if (exp_dv) begin
        h = mq[0];
        tests_run++;
        if ({dv0, dout0, pe0, fe0} !== {1'b1, h.d, h.pe, h.fe}) begin
          tests_failed++;
          $display("FAIL rnd_out0 cyc %0d: got dv=%b d=%h pe=%b fe=%b want 1 %h %b %b",
                   c, dv0, dout0, pe0, fe0, h.d, h.pe, h.fe);
        end
        tests_run++;
        if ({dv1, dout1, pe1, fe1} !== {1'b1, (h.pe || h.fe) ? 8'h00 : h.d, h.pe, h.fe}) begin
          tests_failed++;
          $display("FAIL rnd_out1 cyc %0d: got dv=%b d=%h pe=%b fe=%b want data %h pe %b fe %b",
                   c, dv1, dout1, pe1, fe1, h.d, h.pe, h.fe);
        end
      end else begin
        tests_run++;
        if ({dv0, dv1} !== 2'b00) begin
          tests_failed++;
          $display("FAIL rnd_idle cyc %0d: got dv0=%b dv1=%b want 0 0", c, dv0, dv1);
        end
      end
      tests_run++;
      if ({ov0, ov1} !== {m_ov, m_ov}) begin
        tests_failed++;
        $display("FAIL rnd_overrun cyc %0d: got %b%b want %b", c, ov0, ov1, m_ov);
      end
      e_c0 = {8'(sat(raw_pc, 255)), 8'(sat(raw_fc, 255)), 8'(sat(raw_oc, 255))};
      e_c1 = {2'(sat(raw_pc, 3)), 2'(sat(raw_fc, 3)), 2'(sat(raw_oc, 3))};
      tests_run++;
      if ({pc0, fc0, oc0} !== e_c0) begin
        tests_failed++;
        $display("FAIL rnd_cnt0 cyc %0d: got %h want %h", c, {pc0, fc0, oc0}, e_c0);
      end
      tests_run++;
      if ({pc1, fc1, oc1} !== e_c1) begin
        tests_failed++;
        $display("FAIL rnd_cnt1 cyc %0d: got %h want %h", c, {pc1, fc1, oc1}, e_c1);
      end
    end
    set_idle();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_even_clean();
    test_parity_odd();
    test_stop_bits();
    test_overrun();
    test_saturation();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
